// File: rtl/led_arbiter.sv
// led_arbiter: shares one LED among NUM_REQ requesters with a minimum hold time and blink generation.
// Define LED_RR_ARB_EN for round-robin arbitration with no higher-index preemption.
module led_arbiter #(
    parameter int CLK_HZ          = 12_000_000,
    parameter int TICK_HZ         = 1000,
    parameter int NUM_REQ         = 4,
    parameter int SLOW_HALF_TICKS = 500,
    parameter int FAST_HALF_TICKS = 125,
    parameter int MIN_HOLD_TICKS  = 250
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [2*NUM_REQ-1:0] mode,
    output logic                 led,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 busy
);
    localparam int DIV_T = CLK_HZ / TICK_HZ;
    localparam int DIV   = DIV_T < 1 ? 1 : DIV_T;
    localparam int PW    = DIV > 1 ? $clog2(DIV) : 1;
    localparam int HMAX  = SLOW_HALF_TICKS > FAST_HALF_TICKS ? SLOW_HALF_TICKS : FAST_HALF_TICKS;
    localparam int FW    = $clog2(HMAX + 1);
    localparam int HW    = MIN_HOLD_TICKS > 0 ? $clog2(MIN_HOLD_TICKS + 1) : 1;
    localparam int IW    = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, HOLD, OWN} state_t;

    state_t               state_q, state_d;
    logic [PW-1:0]        presc_q, presc_d;
    logic [NUM_REQ-1:0]   req_q;
    logic [2*NUM_REQ-1:0] mode_in_q;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [IW-1:0]        owner_q, owner_d;
    logic [1:0]           mode_q, mode_d;
    logic [FW-1:0]        phase_q, phase_d;
    logic [HW-1:0]        hold_q, hold_d;
    logic                 led_q, led_d;
    logic                 busy_q, busy_d;
    logic                 tick;
    logic                 owner_req;
    logic [1:0]           cur_mode;
    logic [FW-1:0]        half_m1;
    logic                 rearb;
    logic                 preempt;
    logic [IW-1:0]        win;

    assign tick  = presc_q == PW'(DIV - 1);
    assign led   = led_q;
    assign grant = grant_q;
    assign busy  = busy_q;

`ifdef LED_RR_ARB_EN
    // Search starts just past the last owner and wraps around.
    function automatic logic [IW-1:0] pick_rr(input logic [NUM_REQ-1:0] v, input logic [IW-1:0] ptr);
        logic          found;
        logic [IW-1:0] j;
        pick_rr = '0;
        found   = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            j = IW'((int'(ptr) + k) % NUM_REQ);
            if (!found && v[j]) begin
                pick_rr = j;
                found   = 1'b1;
            end
        end
    endfunction

    assign preempt = 1'b0;
    assign win     = pick_rr(req_q, owner_q);
`else
    function automatic logic [IW-1:0] pick_high(input logic [NUM_REQ-1:0] v);
        pick_high = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (v[i]) pick_high = IW'(i);
    endfunction

    always_comb begin
        preempt = 1'b0;
        for (int i = 0; i < NUM_REQ; i++)
            if (IW'(i) > owner_q && req_q[i]) preempt = 1'b1;
    end

    assign win = pick_high(req_q);
`endif

    always_comb begin
        presc_d   = tick ? '0 : presc_q + PW'(1);
        state_d   = state_q;
        grant_d   = grant_q;
        owner_d   = owner_q;
        mode_d    = mode_q;
        phase_d   = phase_q;
        hold_d    = hold_q;
        led_d     = led_q;
        rearb     = 1'b0;
        owner_req = req_q[owner_q];
        cur_mode  = owner_req ? mode_in_q[{owner_q, 1'b0} +: 2] : mode_q;
        half_m1   = mode_q[0] ? FW'(FAST_HALF_TICKS - 1) : FW'(SLOW_HALF_TICKS - 1);
        if (state_q == IDLE) begin
            rearb = |req_q;
        end else begin
            // A dropped owner keeps its last latched mode until the hold expires.
            mode_d = cur_mode;
            if (cur_mode != mode_q) begin
                phase_d = '0;
                led_d   = |cur_mode;
            end else if (!mode_q[1]) begin
                led_d = mode_q[0];
            end else if (tick && phase_q == half_m1) begin
                phase_d = '0;
                led_d   = !led_q;
            end else if (tick) begin
                phase_d = phase_q + FW'(1);
            end
            if (state_q == HOLD && tick) begin
                hold_d = hold_q == '0 ? '0 : hold_q - HW'(1);
                if (hold_q <= HW'(1)) state_d = OWN;
            end
            if (state_q == OWN) rearb = preempt || !owner_req;
        end
        if (rearb && |req_q) begin
            grant_d      = '0;
            grant_d[win] = 1'b1;
            owner_d      = win;
            mode_d       = mode_in_q[{win, 1'b0} +: 2];
            phase_d      = '0;
            hold_d       = HW'(MIN_HOLD_TICKS);
            led_d        = |mode_d;
            state_d      = MIN_HOLD_TICKS == 0 ? OWN : HOLD;
        end else if (rearb) begin
            grant_d = '0;
            phase_d = '0;
            hold_d  = '0;
            led_d   = 1'b0;
            state_d = IDLE;
        end
        busy_d = |grant_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q   <= '0;
            req_q     <= '0;
            mode_in_q <= '0;
            state_q   <= IDLE;
            grant_q   <= '0;
            owner_q   <= IW'(NUM_REQ - 1);
            mode_q    <= '0;
            phase_q   <= '0;
            hold_q    <= '0;
            led_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            req_q     <= req;
            mode_in_q <= mode;
            state_q   <= state_d;
            grant_q   <= grant_d;
            owner_q   <= owner_d;
            mode_q    <= mode_d;
            phase_q   <= phase_d;
            hold_q    <= hold_d;
            led_q     <= led_d;
            busy_q    <= busy_d;
        end
    end
endmodule

// File: tb/tb_led_arbiter.sv
// tb_led_arbiter: directed checks of arbitration, hold, release, blink timing and async reset.
module tb_led_arbiter;
    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [7:0] mode;
    logic       led;
    logic [3:0] grant;
    logic       busy;
    int         checks;
    int         failures;

    led_arbiter #(
        .CLK_HZ(1000), .TICK_HZ(100), .NUM_REQ(4),
        .SLOW_HALF_TICKS(4), .FAST_HALF_TICKS(2), .MIN_HOLD_TICKS(3)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .mode(mode),
        .led(led), .grant(grant), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1);
    end

    task automatic do_reset();
        rst  = 1'b1;
        req  = '0;
        mode = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    // Cycles the LED holds its current level, measured from the negedge just after it changed.
    task automatic run_len(output int n);
        logic v;
        v = led;
        n = 1;
        while (n < 200) begin
            @(negedge clk);
            if (led !== v) break;
            n++;
        end
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        req  = '0;
        mode = '0;
        repeat (2) @(negedge clk);
        checks++; if (led !== 1'b0) begin failures++; $display("FAIL reset_led got=%b exp=0", led); end
        checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL reset_grant got=%b exp=0000", grant); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        rst = 1'b0;
    endtask

    task automatic test_single();
        int n;
        do_reset();
        req  = 4'b0010;
        mode = 8'b0000_1000;
        @(negedge clk);
        checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL single_latency got=%b exp=0000", grant); end
        @(negedge clk);
        checks++; if (grant !== 4'b0010) begin failures++; $display("FAIL single_grant got=%b exp=0010", grant); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy got=%b exp=1", busy); end
        checks++; if (led !== 1'b1) begin failures++; $display("FAIL single_led_start got=%b exp=1", led); end
        run_len(n);
        checks++; if (n < 31 || n > 40) begin failures++; $display("FAIL single_first_high got=%0d exp=31..40", n); end
        run_len(n);
        checks++; if (n !== 40) begin failures++; $display("FAIL single_low got=%0d exp=40", n); end
        run_len(n);
        checks++; if (n !== 40) begin failures++; $display("FAIL single_high got=%0d exp=40", n); end
        run_len(n);
        checks++; if (n !== 40) begin failures++; $display("FAIL single_low2 got=%0d exp=40", n); end
        checks++; if (led !== 1'b1) begin failures++; $display("FAIL blink_rise got=%b exp=1", led); end
        #2 rst = 1'b1;
        #1;
        checks++; if ({led, grant, busy} !== 6'b0) begin failures++; $display("FAIL reset_async got=%b exp=000000", {led, grant, busy}); end
        repeat (2) @(negedge clk);
        checks++; if ({led, grant, busy} !== 6'b0) begin failures++; $display("FAIL reset_held got=%b exp=000000", {led, grant, busy}); end
        req = '0;
        rst = 1'b0;
    endtask

`ifdef LED_RR_ARB_EN
    task automatic test_rr();
        do_reset();
        req  = 4'b1010;
        mode = 8'b0100_0100;
        repeat (2) @(negedge clk);
        checks++; if (grant !== 4'b0010) begin failures++; $display("FAIL rr_first got=%b exp=0010", grant); end
        repeat (40) @(negedge clk);
        checks++; if (grant !== 4'b0010) begin failures++; $display("FAIL rr_no_preempt got=%b exp=0010", grant); end
        req = 4'b1000;
        @(negedge clk);
        checks++; if (grant !== 4'b0010) begin failures++; $display("FAIL rr_release_latency got=%b exp=0010", grant); end
        @(negedge clk);
        checks++; if (grant !== 4'b1000) begin failures++; $display("FAIL rr_release got=%b exp=1000", grant); end
        checks++; if (led !== 1'b1) begin failures++; $display("FAIL rr_led got=%b exp=1", led); end
    endtask
`else
    task automatic test_hold_release();
        int n;
        do_reset();
        req  = 4'b0001;
        mode = 8'b0000_0001;
        repeat (2) @(negedge clk);
        checks++; if (grant !== 4'b0001) begin failures++; $display("FAIL hold_grant got=%b exp=0001", grant); end
        checks++; if (led !== 1'b1) begin failures++; $display("FAIL hold_led got=%b exp=1", led); end
        n = 1;
        repeat (9) begin @(negedge clk); n++; end
        req  = 4'b1001;
        mode = 8'b0100_0001;
        while (n < 200) begin
            @(negedge clk);
            if (grant !== 4'b0001) break;
            n++;
        end
        checks++; if (n < 22 || n > 31) begin failures++; $display("FAIL hold_duration got=%0d exp=22..31", n); end
        checks++; if (grant !== 4'b1000) begin failures++; $display("FAIL hold_preempt got=%b exp=1000", grant); end
        checks++; if (led !== 1'b1) begin failures++; $display("FAIL hold_preempt_led got=%b exp=1", led); end
        req  = 4'b1100;
        mode = 8'b0111_0001;
        repeat (40) @(negedge clk);
        checks++; if (grant !== 4'b1000) begin failures++; $display("FAIL lower_no_preempt got=%b exp=1000", grant); end
        req = 4'b0100;
        @(negedge clk);
        checks++; if (grant !== 4'b1000) begin failures++; $display("FAIL release_latency got=%b exp=1000", grant); end
        @(negedge clk);
        checks++; if (grant !== 4'b0100) begin failures++; $display("FAIL release_grant got=%b exp=0100", grant); end
        checks++; if (led !== 1'b1) begin failures++; $display("FAIL release_led got=%b exp=1", led); end
        repeat (40) @(negedge clk);
        req = 4'b0000;
        @(negedge clk);
        checks++; if (grant !== 4'b0100) begin failures++; $display("FAIL idle_latency got=%b exp=0100", grant); end
        @(negedge clk);
        checks++; if ({led, grant, busy} !== 6'b0) begin failures++; $display("FAIL idle_outputs got=%b exp=000000", {led, grant, busy}); end
    endtask
`endif

    task automatic test_mode_change();
        int n;
        do_reset();
        req  = 4'b0001;
        mode = 8'b0000_0001;
        repeat (2) @(negedge clk);
        checks++; if (grant !== 4'b0001) begin failures++; $display("FAIL mode_grant got=%b exp=0001", grant); end
        repeat (40) @(negedge clk);
        checks++; if (led !== 1'b1) begin failures++; $display("FAIL mode_solid got=%b exp=1", led); end
        mode = 8'b0000_0011;
        repeat (2) @(negedge clk);
        checks++; if (led !== 1'b1) begin failures++; $display("FAIL mode_fast_start got=%b exp=1", led); end
        run_len(n);
        checks++; if (n < 11 || n > 20) begin failures++; $display("FAIL mode_fast_first_high got=%0d exp=11..20", n); end
        run_len(n);
        checks++; if (n !== 20) begin failures++; $display("FAIL mode_fast_low got=%0d exp=20", n); end
        run_len(n);
        checks++; if (n !== 20) begin failures++; $display("FAIL mode_fast_high got=%0d exp=20", n); end
        mode = 8'b0000_0001;
        @(negedge clk);
        checks++; if (led !== 1'b0) begin failures++; $display("FAIL mode_solid_latency got=%b exp=0", led); end
        @(negedge clk);
        checks++; if (led !== 1'b1) begin failures++; $display("FAIL mode_solid_again got=%b exp=1", led); end
        mode = 8'b0000_0000;
        repeat (2) @(negedge clk);
        checks++; if (led !== 1'b0) begin failures++; $display("FAIL mode_off_led got=%b exp=0", led); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mode_off_busy got=%b exp=1", busy); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        req      = '0;
        mode     = '0;
        rst      = 1'b1;
        test_reset();
        test_single();
`ifdef LED_RR_ARB_EN
        test_rr();
`else
        test_hold_release();
`endif
        test_mode_change();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
